moore_1101_frame_ctrl: RTL

- Frame-level controller for the 1101 Moore sequence detector.
- Accepts a parallel frame with a start/busy/done handshake, clears the detector, and shifts the frame MSB-first into the detector's Din.
- Samples the detector's Y output with the correct Moore latency and counts the hits per frame.
- Sits between a register/host interface and one detector instance; the controller sequences the detector, which it does not contain.

---
 rtl/moore_1101_frame_ctrl_if.sv | 52 +++++
 rtl/moore_1101_frame_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/moore_1101_frame_ctrl_if.sv
//============================================================================
// Module   : moore_1101_frame_ctrl_if
// Purpose  : Host handshake and detector-side signal bundle for the 1101
//            frame controller. The controller uses the slave modport. The
//            environment (host plus detector) uses the master modport.
//            With MOORE_1101_FRAME_CTRL_POS_EN defined, the first-hit
//            position outputs are added to the bundle.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface moore_1101_frame_ctrl_if #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 3
);
    logic               Start_i;
    logic [FRAME_W-1:0] Frame_i;
    logic               Busy_o;
    logic               Done_o;
    logic [CNT_W-1:0]   Hit_cnt_o;
    logic               Det_clr_o;
    logic               Det_din_o;
    logic               Det_y_i;
`ifdef MOORE_1101_FRAME_CTRL_POS_EN
    logic [IDX_W-1:0]   First_pos_o;
    logic               First_vld_o;

    modport master (
        output Start_i, Frame_i, Det_y_i,
        input  Busy_o, Done_o, Hit_cnt_o, Det_clr_o, Det_din_o,
        input  First_pos_o, First_vld_o
    );
    modport slave (
        input  Start_i, Frame_i, Det_y_i,
        output Busy_o, Done_o, Hit_cnt_o, Det_clr_o, Det_din_o,
        output First_pos_o, First_vld_o
    );
`else
    modport master (
        output Start_i, Frame_i, Det_y_i,
        input  Busy_o, Done_o, Hit_cnt_o, Det_clr_o, Det_din_o
    );
    modport slave (
        input  Start_i, Frame_i, Det_y_i,
        output Busy_o, Done_o, Hit_cnt_o, Det_clr_o, Det_din_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/moore_1101_frame_ctrl.sv
//============================================================================
// Module   : moore_1101_frame_ctrl
// Purpose  : Frame-level sequencer for an external Moore 1101 detector.
//            It accepts a parallel frame, clears the detector for one
//            cycle, and shifts the frame MSB-first into the detector's Din.
//            It then samples Y one cycle behind each bit and counts the
//            hits, saturating at the counter's maximum value.
//            Optional: MOORE_1101_FRAME_CTRL_POS_EN adds First_pos_o and
//            First_vld_o, which report the first hit in the frame.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module moore_1101_frame_ctrl #(
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 3
) (
    input  wire logic              Clk,
    input  wire logic              Rst,
    moore_1101_frame_ctrl_if.slave bus
);

    // State encoding
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [2:0]         r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;

    logic w_accept;
    logic w_sample;
    logic w_hit;

    // A start request only counts in IDLE. It is ignored in every other state.
    assign w_accept = (r_state == c_IDLE) && bus.Start_i;

    // Y lags Din by one cycle. The first SHIFT cycle shows the post-clear
    // state, so sampling runs from SHIFT idx 1 up to and including DRAIN.
    assign w_sample = ((r_state == c_SHIFT) && (r_idx != '0)) ||
                      (r_state == c_DRAIN);
    assign w_hit    = w_sample && bus.Det_y_i;

    // Frame sequencing: state, shift register and bit index
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.Start_i) begin
                        r_shreg <= bus.Frame_i;
                        r_state <= c_CLEAR;
                    end
                end
                c_CLEAR: begin
                    r_idx   <= '0;
                    r_state <= c_SHIFT;
                end
                c_SHIFT: begin
                    r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                    r_idx   <= r_idx + c_IDX_ONE;
                    if (r_idx == c_IDX_LAST) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Hit counter: cleared on accept and held after DONE. It saturates
    // rather than wrapping.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Outputs are decoded from registered state only
    assign bus.Busy_o    = (r_state != c_IDLE);
    assign bus.Done_o    = (r_state == c_DONE);
    assign bus.Det_clr_o = (r_state == c_CLEAR);
    assign bus.Det_din_o = (r_state == c_SHIFT) ? r_shreg[FRAME_W-1] : 1'b0;
    assign bus.Hit_cnt_o = r_cnt;

`ifdef MOORE_1101_FRAME_CTRL_POS_EN
    logic [IDX_W-1:0] r_first_pos;
    logic             r_first_vld;
    logic [IDX_W-1:0] w_hit_pos;

    // In SHIFT, Y belongs to the previous bit. In DRAIN, Y belongs to the
    // last bit of the frame.
    assign w_hit_pos = (r_state == c_DRAIN) ? c_IDX_LAST : (r_idx - c_IDX_ONE);

    // Latch the position of the first counted hit; held until the next accept
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_first_pos <= '0;
            r_first_vld <= 1'b0;
        end else if (w_accept) begin
            r_first_pos <= '0;
            r_first_vld <= 1'b0;
        end else if (w_hit && !r_first_vld) begin
            r_first_pos <= w_hit_pos;
            r_first_vld <= 1'b1;
        end
    end

    assign bus.First_pos_o = r_first_pos;
    assign bus.First_vld_o = r_first_vld;
`else
    // No first-hit position tracking in this build
`endif

endmodule

`default_nettype wire
